// File: rtl/ysyx_22050598_lsu_pkg.sv
// Shared widths, FSM encoding, funct3 constants and request payload for the load/store unit.
package ysyx_22050598_lsu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned MASK_W = XLEN / 8;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  // An access is misaligned when it crosses its own natural size boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      SZ_D:    mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_22050598_lsu_align.sv
// Store byte-lane/mask placement and load extract plus sign/zero extension.
module ysyx_22050598_lsu_align
  import ysyx_22050598_lsu_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [2:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_wdata,
  output logic [MASK_W-1:0] st_wmask,
  input  logic [2:0]        ld_funct3,
  input  logic [2:0]        ld_off,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data
);

  logic [MASK_W-1:0] base_mask;
  logic [XLEN-1:0]   ld_shift;

  always_comb begin
    base_mask = '0;
    case (st_size)
      SZ_B:    base_mask = MASK_W'(1);
      SZ_H:    base_mask = MASK_W'(3);
      SZ_W:    base_mask = MASK_W'(15);
      default: base_mask = '1;
    endcase
    st_wmask = base_mask << st_off;
    st_wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    ld_data  = ld_shift;
    case (ld_funct3)
      F3_LB:   ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      F3_LH:   ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      F3_LW:   ld_data = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      F3_LWU:  ld_data = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/ysyx_22050598_lsu.sv
// Load/store stage: ALU passthrough, one memory handshake per access, stall/bubble control.
module ysyx_22050598_lsu
  import ysyx_22050598_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  input  logic              ls_mem_rd,
  input  logic              ls_mem_wr,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_mem_addr,
  input  logic [XLEN-1:0]   ls_st_data,
  input  logic [XLEN-1:0]   ls_alu_data,
  input  logic              ls_rd_en,
  input  logic [4:0]        ls_rd_idx,
  input  logic              ls_is_ebreak,
  input  logic              ls_wb_stall,
  output logic              ls_stall_o,
  output logic              ls_misalign_o,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  output logic [XLEN-1:0]   ls_wb_rd_data,
  output logic              ls_wb_rd_en,
  output logic [4:0]        ls_wb_rd_idx,
  output logic              ls_wb_inst_is_ebreak
);

  lsu_state_e      state_q, state_d;
  mem_req_t        req_q, req_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [2:0]      ld_off_q, ld_off_d;

  logic              is_mem;
  logic              misalign;
  logic              go_req;
  logic [XLEN-1:0]   st_wdata;
  logic [MASK_W-1:0] st_wmask;
  logic [XLEN-1:0]   ld_data;

  assign is_mem   = ls_valid & (ls_mem_rd | ls_mem_wr);
  assign misalign = is_mem & is_misaligned(ls_funct3[1:0], ls_mem_addr[2:0]);
  assign go_req   = is_mem & ~misalign;

  ysyx_22050598_lsu_align u_align (
    .st_size   (ls_funct3[1:0]),
    .st_off    (ls_mem_addr[2:0]),
    .st_data   (ls_st_data),
    .st_wdata  (st_wdata),
    .st_wmask  (st_wmask),
    .ld_funct3 (ld_f3_q),
    .ld_off    (ld_off_q),
    .ld_rdata  (buf_q),
    .ld_data   (ld_data)
  );

  // Next-state: the request payload and load format are frozen when leaving IDLE.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    req_valid_d = req_valid_q;
    buf_d       = buf_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (go_req) begin
          state_d     = LSU_REQ;
          req_valid_d = 1'b1;
          req_d.we    = ls_mem_wr;
          req_d.addr  = {ls_mem_addr[ADDR_W-1:3], 3'b000};
          req_d.wdata = ls_mem_wr ? st_wdata : '0;
          req_d.wmask = ls_mem_wr ? st_wmask : '0;
          ld_f3_d     = ls_funct3;
          ld_off_d    = ls_mem_addr[2:0];
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          if (mem_resp_valid) begin
            state_d = LSU_DONE;
            buf_d   = mem_resp_rdata;
          end else begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (mem_resp_valid) begin
          state_d = LSU_DONE;
          buf_d   = mem_resp_rdata;
        end
      end
      LSU_DONE: begin
        if (!ls_wb_stall) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Writeback/stall view; REQ and WAIT present a bubble to LS_WB.
  always_comb begin
    ls_wb_rd_data        = '0;
    ls_wb_rd_en          = 1'b0;
    ls_wb_rd_idx         = ls_rd_idx;
    ls_wb_inst_is_ebreak = 1'b0;
    ls_stall_o           = 1'b0;
    ls_misalign_o        = 1'b0;
    unique case (state_q)
      LSU_IDLE: begin
        ls_wb_rd_data        = ls_alu_data;
        ls_wb_rd_en          = ls_rd_en & ~is_mem;
        ls_wb_inst_is_ebreak = ls_is_ebreak;
        ls_stall_o           = rst & go_req;
        ls_misalign_o        = rst & misalign;
      end
      LSU_REQ, LSU_WAIT: begin
        ls_stall_o = 1'b1;
      end
      LSU_DONE: begin
        ls_wb_rd_data        = ld_data;
        ls_wb_rd_en          = ls_rd_en & ~req_q.we;
        ls_wb_inst_is_ebreak = ls_is_ebreak;
      end
      default: ls_stall_o = 1'b0;
    endcase
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = req_q.we;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_wmask = req_q.wmask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LSU_IDLE;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      buf_q       <= '0;
      ld_f3_q     <= '0;
      ld_off_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      buf_q       <= buf_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
    end
  end

endmodule
